uart_tx_fifo: RTL and testbench

Memory-mapped UART transmitter for the SoC IO page, replacing the single-byte emitter with a buffered, parametrised one. CPU stores are queued in a FIFO and serialised on `txd` with configurable frame format. Software polling of status bit 9 (busy) keeps its current meaning. Adds level, full/empty, sticky overflow and flush.

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Memory-mapped buffered UART transmitter: CPU writes are queued in a FIFO and serialised on txd
// with configurable data/stop bits. STATUS exposes empty/full/overflow/busy and the FIFO level.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 1000000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_sel,
  input  logic [1:0]  io_reg,
  input  logic        io_wstrb,
  input  logic        io_rstrb,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CW  = (DIV >= 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DivM1    = CW'(DIV - 1);
  localparam logic [2:0]    LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LastStop = 3'(STOP_BITS - 1);

  if (DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : gen_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [LW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level;
  logic          empty, full;
  logic          wr_data, wr_ctrl, push, pop, flush;
  logic          ovf_q;
  logic [7:0]    pop_data;
  logic [31:0]   status;

  state_e        state_q;
  logic [CW-1:0] bcnt_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          bit_end;

  assign level    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign wr_data  = io_sel && io_wstrb && (io_reg == 2'd0);
  assign wr_ctrl  = io_sel && io_wstrb && (io_reg == 2'd2);
  assign flush    = wr_ctrl && io_wdata[1];
  assign bit_end  = (bcnt_q == '0);
  assign pop_data = mem_q[rptr_q[AW-1:0]];

  // Pop in IDLE, or at the very end of the last stop bit for gapless back-to-back frames.
  assign pop  = !empty && ((state_q == StIdle) ||
                           (state_q == StStop && bit_end && bitcnt_q == LastStop));
  assign push = wr_data && (!full || pop);

  assign busy = !empty || (state_q != StIdle);
  assign txd  = txd_q;

  always_comb begin
    status          = '0;
    status[0]       = empty;
    status[1]       = full;
    status[2]       = ovf_q;
    status[9]       = busy;
    status[16 +: LW] = level;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      io_rdata <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (flush)    rptr_q <= wptr_q;
      else if (pop) rptr_q <= rptr_q + 1'b1;
      if (wr_data && !push)              ovf_q <= 1'b1;
      else if (wr_ctrl && io_wdata[0])   ovf_q <= 1'b0;
      if (io_sel && io_rstrb) io_rdata <= (io_reg == 2'd1) ? status : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      txd_q    <= 1'b1;
      bcnt_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= pop_data;
            txd_q   <= 1'b0;
            bcnt_q  <= DivM1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            txd_q    <= shift_q[0];
            bitcnt_q <= '0;
            bcnt_q   <= DivM1;
            state_q  <= StData;
          end else begin
            bcnt_q <= bcnt_q - 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            bcnt_q <= DivM1;
            if (bitcnt_q == LastData) begin
              txd_q    <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= StStop;
            end else begin
              shift_q  <= shift_q >> 1;
              txd_q    <= shift_q[1];
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q - 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            bcnt_q <= DivM1;
            if (bitcnt_q == LastStop) begin
              bitcnt_q <= '0;
              if (pop) begin
                shift_q <= pop_data;
                txd_q   <= 1'b0;
                state_q <= StStart;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo: two instances (8N1 depth 4, 7 data/2 stop depth 16)
// on a shared bus; txd/busy are logged per cycle and compared against frames built from the bytes.
module tb_uart_tx_fifo;

  localparam int DIV  = 100;
  localparam int LOGN = 60000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_a, sel_b;
  logic [1:0]  io_reg;
  logic        io_wstrb, io_rstrb;
  logic [31:0] io_wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        txd_a, txd_b, busy_a, busy_b;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic log_ta [LOGN];
  logic log_ba [LOGN];
  logic log_tb [LOGN];

  uart_tx_fifo #(
    .CLK_FREQ_HZ(100000000), .BAUD_RATE(1000000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .io_sel(sel_a), .io_reg(io_reg), .io_wstrb(io_wstrb),
    .io_rstrb(io_rstrb), .io_wdata(io_wdata), .io_rdata(rdata_a), .txd(txd_a), .busy(busy_a)
  );

  uart_tx_fifo #(
    .CLK_FREQ_HZ(100000000), .BAUD_RATE(1000000), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_b (
    .clk(clk), .reset(reset), .io_sel(sel_b), .io_reg(io_reg), .io_wstrb(io_wstrb),
    .io_rstrb(io_rstrb), .io_wdata(io_wdata), .io_rdata(rdata_b), .txd(txd_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; log[n] holds the value settled after edge n.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_ta[cyc] = txd_a;
      log_ba[cyc] = busy_a;
      log_tb[cyc] = txd_b;
    end
  end

  function automatic logic [31:0] st(input bit e, input bit f, input bit o, input bit b,
                                     input int lvl);
    st = (32'(lvl) << 16) | (32'(b) << 9) | (32'(o) << 2) | (32'(f) << 1) | 32'(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic bus_write(input bit use_b, input logic [1:0] r, input logic [31:0] d,
                           output int edge_idx);
    sel_a = !use_b; sel_b = use_b; io_reg = r; io_wdata = d; io_wstrb = 1'b1;
    @(posedge clk); #1;
    edge_idx = cyc;
    sel_a = 1'b0; sel_b = 1'b0; io_wstrb = 1'b0;
  endtask

  task automatic bus_read(input bit use_b, input logic [1:0] r, output logic [31:0] d);
    sel_a = !use_b; sel_b = use_b; io_reg = r; io_rstrb = 1'b1;
    @(posedge clk); #1;
    sel_a = 1'b0; sel_b = 1'b0; io_rstrb = 1'b0;
    d = use_b ? rdata_b : rdata_a;
  endtask

  // Park just after edge target-1 so the next bus cycle is sampled at edge target.
  task automatic goto_edge(input int target);
    while (cyc < target - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input bit use_b, input int max_cyc);
    int n = 0;
    while ((use_b ? busy_b : busy_a) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 32'(use_b ? busy_b : busy_a), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference frame: start 0, data LSB first, stop 1s, each bit DIV cycles, frames gapless.
  task automatic check_frames(input string tag, input bit use_b, input int start,
                              input logic [7:0] bytes[$], input int dbits, input int sbits);
    int flen = (1 + dbits + sbits) * DIV;
    int idx, bi, errs;
    logic e, a;
    chk({tag, "_high_before"}, 32'(use_b ? log_tb[start-1] : log_ta[start-1]), 32'd1);
    foreach (bytes[f]) begin
      errs = 0;
      for (int t = 0; t < flen; t++) begin
        bi  = t / DIV;
        idx = start + f * flen + t;
        if (bi == 0)          e = 1'b0;
        else if (bi <= dbits) e = bytes[f][bi-1];
        else                  e = 1'b1;
        a = use_b ? log_tb[idx] : log_ta[idx];
        if (a !== e) errs++;
      end
      chk($sformatf("%s_frame%0d_bad_cycles", tag, f), 32'(errs), 32'd0);
    end
    idx = start + bytes.size() * flen;
    chk({tag, "_idle_after"}, 32'(use_b ? log_tb[idx] : log_ta[idx]), 32'd1);
  endtask

  initial begin
    int e0, e1, n, lows;
    logic [31:0] d;
    logic [7:0] q[$];
    logic [7:0] b[6];

    reset = 1'b0; sel_a = 1'b0; sel_b = 1'b0; io_reg = '0;
    io_wstrb = 1'b0; io_rstrb = 1'b0; io_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    chk("reset_txd_a", 32'(txd_a), 32'd1);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_rdata_a", rdata_a, 32'd0);
    chk("reset_txd_b", 32'(txd_b), 32'd1);
    bus_read(1'b0, 2'd1, d); chk("reset_status_a", d, 32'h1);
    bus_read(1'b1, 2'd1, d); chk("reset_status_b", d, 32'h1);

    // Single byte 0x41
    bus_write(1'b0, 2'd0, 32'h41, e0);
    wait_idle(1'b0, 2000);
    q = {8'h41};
    check_frames("single", 1'b0, e0 + 1, q, 8, 1);
    chk("single_busy_last", 32'(log_ba[e0 + 1000]), 32'd1);
    chk("single_busy_drop", 32'(log_ba[e0 + 1001]), 32'd0);

    // DATA reads return 0, reserved register ignored
    bus_write(1'b0, 2'd3, 32'hFF, e1);
    bus_read(1'b0, 2'd0, d); chk("data_read_zero", d, 32'd0);
    bus_read(1'b0, 2'd1, d); chk("reserved_write_ignored", d, 32'h1);

    // Back-to-back
    bus_write(1'b0, 2'd0, 32'h55, e0);
    bus_write(1'b0, 2'd0, 32'hAA, e1);
    bus_write(1'b0, 2'd0, 32'h0F, e1);
    bus_read(1'b0, 2'd1, d); chk("b2b_status_level2", d, st(0, 0, 0, 1, 2));
    wait_idle(1'b0, 4000);
    q = {8'h55, 8'hAA, 8'h0F};
    check_frames("b2b", 1'b0, e0 + 1, q, 8, 1);
    chk("b2b_busy_drop", 32'(log_ba[e0 + 3001]), 32'd0);

    // Random bursts of up to 5 bytes (depth 4 plus the immediate pop)
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom_range(0, 255)));
        bus_write(1'b0, 2'd0, {24'h0, q[i]}, e1);
        if (i == 0) e0 = e1;
      end
      wait_idle(1'b0, 6000);
      check_frames($sformatf("rand%0d", r), 1'b0, e0 + 1, q, 8, 1);
    end

    // Overflow, clear, and a write at full coinciding with a pop
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      bus_write(1'b0, 2'd0, {24'h0, b[i]}, e1);
      if (i == 0) e0 = e1;
    end
    bus_read(1'b0, 2'd1, d); chk("ovf_status", d, st(0, 1, 1, 1, 4));
    bus_write(1'b0, 2'd2, 32'h1, e1);
    bus_read(1'b0, 2'd1, d); chk("ovf_cleared", d, st(0, 1, 0, 1, 4));
    goto_edge(e0 + 1001);
    bus_write(1'b0, 2'd0, 32'h3C, e1);
    chk("coincide_edge", 32'(e1), 32'(e0 + 1001));
    bus_read(1'b0, 2'd1, d); chk("coincide_status", d, st(0, 1, 0, 1, 4));
    wait_idle(1'b0, 7000);
    q = {b[0], b[1], b[2], b[3], b[4], 8'h3C};
    check_frames("ovf", 1'b0, e0 + 1, q, 8, 1);

    // Flush mid-frame
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      bus_write(1'b0, 2'd0, {24'h0, b[i]}, e1);
      if (i == 0) e0 = e1;
    end
    goto_edge(e0 + 400);
    bus_write(1'b0, 2'd2, 32'h2, e1);
    wait_idle(1'b0, 2000);
    repeat (300) begin
      @(posedge clk); #1;
    end
    q = {b[0]};
    check_frames("flush", 1'b0, e0 + 1, q, 8, 1);
    lows = 0;
    for (int t = e0 + 1001; t < e0 + 1300; t++) if (log_ta[t] !== 1'b1) lows++;
    chk("flush_no_more_frames", 32'(lows), 32'd0);
    bus_read(1'b0, 2'd1, d); chk("flush_status", d, 32'h1);

    // 7 data bits, 2 stop bits
    bus_write(1'b1, 2'd0, 32'h7F, e0);
    wait_idle(1'b1, 2000);
    q = {8'h7F};
    check_frames("fmt7n2", 1'b1, e0 + 1, q, 7, 2);

    // Asynchronous reset mid-frame
    bus_write(1'b1, 2'd0, 32'h00, e0);
    bus_write(1'b1, 2'd0, 32'h12, e1);
    bus_write(1'b1, 2'd0, 32'h34, e1);
    goto_edge(e0 + 351);
    chk("pre_reset_txd_low", 32'(txd_b), 32'd0);
    reset = 1'b0;
    #1;
    chk("async_reset_txd", 32'(txd_b), 32'd1);
    chk("async_reset_busy", 32'(busy_b), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bus_read(1'b1, 2'd1, d); chk("post_reset_status_b", d, 32'h1);
    repeat (300) begin
      @(posedge clk); #1;
    end
    chk("post_reset_txd_idle", 32'(txd_b), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
